funnel_wrr_arbiter: RTL and testbench

// - Weighted round-robin scheduler that merges FUNNEL_WIDTH independent enq-style pipes into one output pipe.
// - Sits between a bank of per-lane FIFOs and a single result FIFO, and shares that FIFO between the lanes.
// - Each lane gets a runtime-programmable burst weight.
// - Replaces the fixed funnel when lanes need unequal bandwidth shares.

---
 rtl/funnel_pkg.sv | 34 +++
 rtl/funnel_wrr_pick.sv | 25 ++
 rtl/funnel_wrr_arbiter.sv | 115 +++++++++++
 tb/tb_funnel_wrr_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/funnel_pkg.sv
// Shared types and the rotate-priority search used by the WRR funnel.
package funnel_pkg;

  localparam int unsigned FUNNEL_WIDTH_DEF = 4;
  localparam int unsigned MAX_LANES        = 16;
  localparam int unsigned WEIGHT_W_DEF     = 4;

  typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;
  typedef logic [WEIGHT_W_DEF-1:0]      weight_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } pick_t;

  // First set bit of held[0..n-1] searching ptr, ptr+1, ... wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_LANES-1:0] held,
                                    input lane_idx_t ptr,
                                    input int unsigned n);
    pick_t       res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !res.found && held[lane_idx_t'(k)]) begin
        res.found = 1'b1;
        res.idx   = lane_idx_t'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/funnel_wrr_pick.sv
// Combinational rotate-priority encoder: picks the first held lane from ptr_i.
module funnel_wrr_pick
  import funnel_pkg::*;
#(
  parameter int unsigned N = FUNNEL_WIDTH_DEF
) (
  input  logic [N-1:0]         held_i,
  input  lane_idx_t            ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  logic [MAX_LANES-1:0] held_ext;
  pick_t                pick;

  always_comb begin
    held_ext         = '0;
    held_ext[N-1:0]  = held_i;
    pick             = rr_pick(held_ext, ptr_i, N);
  end

  assign found_o = pick.found;
  assign idx_o   = ($clog2(N))'(pick.idx);

endmodule

// File: rtl/funnel_wrr_arbiter.sv
// Weighted round-robin funnel: per-lane holding registers merged into one
// registered output pipe, with programmable per-lane burst weights.
module funnel_wrr_arbiter
  import funnel_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FUNNEL_WIDTH = FUNNEL_WIDTH_DEF,
  parameter int unsigned WEIGHT_W     = WEIGHT_W_DEF
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic [FUNNEL_WIDTH-1:0]         in_enq__ENA,
  input  logic [FUNNEL_WIDTH*WIDTH-1:0]   in_enq_v,
  output logic [FUNNEL_WIDTH-1:0]         in_enq__RDY,
  output logic                            out_enq__ENA,
  output logic [WIDTH-1:0]                out_enq_v,
  input  logic                            out_enq__RDY,
  output logic [$clog2(FUNNEL_WIDTH)-1:0] out_lane,
  input  logic                            cfg_wr__ENA,
  input  logic [$clog2(FUNNEL_WIDTH)-1:0] cfg_idx,
  input  logic [WEIGHT_W-1:0]             cfg_weight,
  output logic                            busy
);

  localparam int unsigned IDX_W = $clog2(FUNNEL_WIDTH);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(FUNNEL_WIDTH - 1);

  logic [FUNNEL_WIDTH-1:0] held_q, held_d;
  logic [WIDTH-1:0]        lane_data_q [FUNNEL_WIDTH];
  logic                    out_valid_q;
  logic [WIDTH-1:0]        out_data_q;
  logic [IDX_W-1:0]        out_lane_q;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]     cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]     weight_q [FUNNEL_WIDTH];

  logic                    can_load, found, grant;
  logic [IDX_W-1:0]        g;
  logic [FUNNEL_WIDTH-1:0] gnt_vec, rdy, cap;
  logic [WEIGHT_W-1:0]     eff;
  logic [WEIGHT_W:0]       cnt_inc, eff_ext;

  funnel_wrr_pick #(.N(FUNNEL_WIDTH)) u_pick (
    .held_i  (held_q),
    .ptr_i   (lane_idx_t'(ptr_q)),
    .found_o (found),
    .idx_o   (g)
  );

  always_comb begin
    can_load = !out_valid_q || out_enq__RDY;
    grant    = can_load && found;
    for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
      gnt_vec[i] = grant && (g == IDX_W'(i));
    end
    // A lane being granted reports ready so it can refill in the same cycle.
    rdy    = ~held_q | gnt_vec;
    cap    = in_enq__ENA & rdy;
    held_d = (held_q & ~gnt_vec) | cap;

    eff     = (weight_q[ptr_q] == '0) ? WEIGHT_W'(1) : weight_q[ptr_q];
    cnt_inc = {1'b0, cnt_q} + {{WEIGHT_W{1'b0}}, 1'b1};
    eff_ext = {1'b0, eff};
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (grant) begin
      if (g == ptr_q && cnt_inc < eff_ext) begin
        cnt_d = cnt_inc[WEIGHT_W-1:0];
      end else begin
        ptr_d = (g == LAST_LANE) ? '0 : g + IDX_W'(1);
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      held_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      held_q <= held_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      if (can_load) begin
        out_valid_q <= found;
        if (found) begin
          out_data_q <= lane_data_q[g];
          out_lane_q <= g;
        end
      end
      if (cfg_wr__ENA && (32'(cfg_idx) < FUNNEL_WIDTH)) weight_q[cfg_idx] <= cfg_weight;
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
      if (cap[i]) lane_data_q[i] <= in_enq_v[i*WIDTH +: WIDTH];
    end
  end

  assign in_enq__RDY  = rdy;
  assign out_enq__ENA = out_valid_q;
  assign out_enq_v    = out_valid_q ? out_data_q : '0;
  assign out_lane     = out_lane_q;
  assign busy         = (|held_q) || out_valid_q;

  a_enq_protocol: assert property (@(posedge CLK) disable iff (!nRST)
    (in_enq__ENA & ~in_enq__RDY) == '0);

endmodule

// File: tb/tb_funnel_wrr_arbiter.sv
// Directed bench for funnel_wrr_arbiter: grant order, weighting, stall and reset.
module tb_funnel_wrr_arbiter;
  import funnel_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic [N-1:0]   in_enq__ENA = '0;
  logic [N*W-1:0] in_enq_v = '0;
  logic [N-1:0]   in_enq__RDY;
  logic           out_enq__ENA;
  logic [W-1:0]   out_enq_v;
  logic           out_enq__RDY = 1'b0;
  logic [1:0]     out_lane;
  logic           cfg_wr__ENA = 1'b0;
  logic [1:0]     cfg_idx = '0;
  weight_t        cfg_weight = '0;
  logic           busy;

  funnel_wrr_arbiter #(.WIDTH(W), .FUNNEL_WIDTH(N), .WEIGHT_W(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_enq__ENA),
    .in_enq_v     (in_enq_v),
    .in_enq__RDY  (in_enq__RDY),
    .out_enq__ENA (out_enq__ENA),
    .out_enq_v    (out_enq_v),
    .out_enq__RDY (out_enq__RDY),
    .out_lane     (out_lane),
    .cfg_wr__ENA  (cfg_wr__ENA),
    .cfg_idx      (cfg_idx),
    .cfg_weight   (cfg_weight),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [N-1:0] active = '0;
  int unsigned tx_seq [N];
  int unsigned exp_seq [N];
  int unsigned pat [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: sets downstream ready, then offers beats on ready lanes.
  task automatic drive(input logic rdy);
    out_enq__RDY = rdy;
    #1;
    in_enq__ENA = active & in_enq__RDY;
    for (int i = 0; i < int'(N); i++) begin
      in_enq_v[i*W +: W] = {8'(i), 24'(tx_seq[i])};
      if (in_enq__ENA[i]) tx_seq[i]++;
    end
  endtask

  task automatic do_reset();
    active       = '0;
    in_enq__ENA  = '0;
    cfg_wr__ENA  = 1'b0;
    out_enq__RDY = 1'b0;
    nRST         = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      tx_seq[i]  = 0;
      exp_seq[i] = 0;
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic cfg_write(input int unsigned idx, input int unsigned w);
    in_enq__ENA = '0;
    cfg_wr__ENA = 1'b1;
    cfg_idx     = 2'(idx);
    cfg_weight  = 4'(w);
    @(negedge CLK);
    cfg_wr__ENA = 1'b0;
  endtask

  // Expects the lanes in pat[] on consecutive cycles, downstream always ready.
  task automatic run_expect(input string name);
    int unsigned budget = 16;
    int unsigned l;
    while (!out_enq__ENA && budget > 0) begin
      drive(1'b1);
      @(negedge CLK);
      budget--;
    end
    check_val({name, " first beat"}, 32'(out_enq__ENA), 32'd1);
    foreach (pat[k]) begin
      l = pat[k];
      check_val($sformatf("%s b%0d ena", name, k), 32'(out_enq__ENA), 32'd1);
      check_val($sformatf("%s b%0d lane", name, k), 32'(out_lane), l);
      check_val($sformatf("%s b%0d data", name, k), out_enq_v, {8'(l), 24'(exp_seq[l])});
      exp_seq[l]++;
      drive(1'b1);
      @(negedge CLK);
    end
  endtask

  initial begin
    // Reset with lanes loaded and the output register full.
    do_reset();
    active = '1;
    drive(1'b0);
    @(negedge CLK);
    drive(1'b0);
    @(negedge CLK);
    check_val("preload busy", 32'(busy), 32'd1);
    check_val("preload ena", 32'(out_enq__ENA), 32'd1);
    active = '0;
    in_enq__ENA = '0;
    #2 nRST = 1'b0;
    #1;
    check_val("rst rdy", 32'(in_enq__RDY), 32'hF);
    check_val("rst ena", 32'(out_enq__ENA), 32'd0);
    check_val("rst data", out_enq_v, 32'd0);
    check_val("rst lane", 32'(out_lane), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check_val("post-rst rdy", 32'(in_enq__RDY), 32'hF);
    check_val("post-rst ena", 32'(out_enq__ENA), 32'd0);
    check_val("post-rst busy", 32'(busy), 32'd0);

    // Default weights: plain round robin at one beat per clock.
    do_reset();
    active = '1;
    pat = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_expect("rr");

    // Lane 0 weight 3: bursts of three, half the bandwidth.
    do_reset();
    cfg_write(0, 3);
    active = '1;
    pat = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
    run_expect("w3111");

    // Single active lane is served every cycle.
    do_reset();
    cfg_write(2, 2);
    active = 4'b0100;
    pat = '{2, 2, 2, 2, 2, 2, 2, 2};
    run_expect("solo2");

    // Downstream stall with all lanes full, then release.
    do_reset();
    active = '1;
    pat = '{0, 1, 2, 3};
    run_expect("prestall");
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("stall%0d ena", c), 32'(out_enq__ENA), 32'd1);
      check_val($sformatf("stall%0d lane", c), 32'(out_lane), 32'd0);
      check_val($sformatf("stall%0d data", c), out_enq_v, {8'd0, 24'd1});
      drive(1'b0);
      check_val($sformatf("stall%0d rdy", c), 32'(in_enq__RDY), 32'h0);
      @(negedge CLK);
    end
    pat = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_expect("release");

    // Lane 0 weight cut 3->1 while burst_cnt=1: burst ends at next grant.
    do_reset();
    cfg_write(0, 3);
    active = '1;
    drive(1'b1);
    @(negedge CLK);
    drive(1'b1);
    @(negedge CLK);
    check_val("cut first ena", 32'(out_enq__ENA), 32'd1);
    check_val("cut first lane", 32'(out_lane), 32'd0);
    cfg_wr__ENA = 1'b1;
    cfg_idx     = 2'd0;
    cfg_weight  = 4'd1;
    drive(1'b0);
    @(negedge CLK);
    cfg_wr__ENA = 1'b0;
    drive(1'b0);
    @(negedge CLK);
    pat = '{0, 0, 1, 2, 3, 0, 1, 2};
    run_expect("wcut");

    // A weight of zero behaves as one.
    do_reset();
    cfg_write(0, 0);
    active = '1;
    pat = '{0, 1, 2, 3, 0};
    run_expect("w0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
